// File: rtl/anton_neopixel_decoder_pkg.sv
// Shared defaults, FSM encoding and sizing helpers for the NeoPixel receive decoder.
package anton_neopixel_decoder_pkg;

   localparam int BUFFER_END_DEFAULT           = 255;
   localparam int RESET_DELAY_DEFAULT          = 384;  // 60 us of low at 6.4 MHz
   localparam int NEO_DECODE_THRESHOLD_DEFAULT = 3;
   localparam int NEO_DECODE_HIGH_MAX_DEFAULT  = 7;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      IDLE      = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } dec_state_t;

   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int sanitize_buffer_end(input int value);
      return (value < 0) ? 0 : value;
   endfunction

endpackage

// File: rtl/anton_neopixel_line_sync.sv
// Two-flop synchronizer for the serial line, with single-cycle rise/fall strobes on the synced sample.
module anton_neopixel_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sample,
   output logic rise,
   output logic fall
);

   logic meta_p0;
   logic sample_p1;
   logic prev_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_p0   <= 1'b0;
         sample_p1 <= 1'b0;
         prev_p2   <= 1'b0;
      end else begin
         meta_p0   <= din;
         sample_p1 <= meta_p0;
         prev_p2   <= sample_p1;
      end
   end

   assign sample = sample_p1;
   assign rise   = sample_p1 & ~prev_p2;
   assign fall   = ~sample_p1 & prev_p2;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// WS2812-style line receiver: classifies high pulse widths into bits, packs MSB-first bytes,
// and delimits frames by the latch gap.
module anton_neopixel_decoder
   import anton_neopixel_decoder_pkg::*;
#(
   parameter int  BUFFER_END     = BUFFER_END_DEFAULT,
   parameter int  RESET_DELAY    = RESET_DELAY_DEFAULT,
   parameter int  HIGH_THRESHOLD = NEO_DECODE_THRESHOLD_DEFAULT,
   parameter int  HIGH_MAX       = NEO_DECODE_HIGH_MAX_DEFAULT,
   localparam int BUFFER_BITS    = clog2_min1(sanitize_buffer_end(BUFFER_END) + 1)
) (
   input  logic                   clk6_4mhz,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   neoDataIn,
   output logic                   byteValid,
   output logic [7:0]             byteData,
   output logic [BUFFER_BITS-1:0] byteIx,
   output logic                   frameDone,
   output logic [BUFFER_BITS:0]   frameBytes,
   output logic                   errGlitch,
   output logic                   errPartial,
   output logic                   errOverflow,
   output logic                   state
);

   localparam int HC_W = clog2_min1(HIGH_MAX + 2);
   localparam int LC_W = clog2_min1(RESET_DELAY + 1);
   localparam logic [HC_W-1:0]        HIGH_LIM = HC_W'(HIGH_MAX);
   localparam logic [HC_W-1:0]        THR      = HC_W'(HIGH_THRESHOLD);
   localparam logic [LC_W-1:0]        LOW_END  = LC_W'(RESET_DELAY);
   localparam logic [BUFFER_BITS:0]   BUF_LAST = (BUFFER_BITS + 1)'(sanitize_buffer_end(BUFFER_END));

   logic s, rise, fall;

   anton_neopixel_line_sync u_line_sync (
      .clk    (clk6_4mhz),
      .reset  (reset),
      .din    (neoDataIn),
      .sample (s),
      .rise   (rise),
      .fall   (fall)
   );

   dec_state_t             fsm, fsm_nxt;
   logic [HC_W-1:0]        high_cnt, high_nxt, high_inc;
   logic [LC_W-1:0]        low_cnt, low_nxt, low_inc;
   logic [2:0]             bit_cnt, bit_nxt;
   logic [6:0]             shreg, shreg_nxt;
   logic [7:0]             new_byte;
   logic [BUFFER_BITS:0]   acc_cnt, acc_nxt;
   logic                   ovf_flag, ovf_nxt;
   logic                   byte_valid_nxt, frame_done_nxt;
   logic                   glitch_nxt, partial_nxt, overflow_nxt;
   logic [7:0]             byte_data_nxt;
   logic [BUFFER_BITS-1:0] byte_ix_nxt;
   logic [BUFFER_BITS:0]   frame_bytes_nxt;

   always_comb begin
      fsm_nxt         = fsm;
      high_nxt        = high_cnt;
      low_nxt         = low_cnt;
      bit_nxt         = bit_cnt;
      shreg_nxt       = shreg;
      acc_nxt         = acc_cnt;
      ovf_nxt         = ovf_flag;
      byte_valid_nxt  = 1'b0;
      byte_data_nxt   = byteData;
      byte_ix_nxt     = byteIx;
      frame_done_nxt  = 1'b0;
      frame_bytes_nxt = frameBytes;
      glitch_nxt      = 1'b0;
      partial_nxt     = 1'b0;
      overflow_nxt    = 1'b0;
      low_inc         = low_cnt + 1'b1;
      high_inc        = (high_cnt > HIGH_LIM) ? high_cnt : high_cnt + 1'b1;
      new_byte        = {shreg, (high_cnt > THR)};

      if (!enable) begin
         fsm_nxt   = WAIT_SYNC;
         high_nxt  = '0;
         low_nxt   = '0;
         bit_nxt   = '0;
         shreg_nxt = '0;
         acc_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         unique case (fsm)
            WAIT_SYNC: begin
               if (s) begin
                  low_nxt = '0;
               end else if (low_inc == LOW_END) begin
                  low_nxt = '0;
                  fsm_nxt = IDLE;
               end else begin
                  low_nxt = low_inc;
               end
            end
            IDLE: begin
               if (rise) begin
                  fsm_nxt   = HIGH;
                  high_nxt  = HC_W'(1);
                  bit_nxt   = '0;
                  shreg_nxt = '0;
                  acc_nxt   = '0;
                  ovf_nxt   = 1'b0;
               end
            end
            HIGH: begin
               if (s) begin
                  if (high_inc > HIGH_LIM) begin
                     glitch_nxt = 1'b1;
                     fsm_nxt    = WAIT_SYNC;
                     low_nxt    = '0;
                     bit_nxt    = '0;
                     shreg_nxt  = '0;
                  end else begin
                     high_nxt = high_inc;
                  end
               end else if (fall) begin
                  fsm_nxt = LOW;
                  low_nxt = LC_W'(1);
                  // The falling sample commits the bit; a full byte beyond the buffer is dropped.
                  if (bit_cnt == 3'd7) begin
                     bit_nxt   = '0;
                     shreg_nxt = '0;
                     if (acc_cnt <= BUF_LAST) begin
                        byte_valid_nxt = 1'b1;
                        byte_data_nxt  = new_byte;
                        byte_ix_nxt    = acc_cnt[BUFFER_BITS-1:0];
                        acc_nxt        = acc_cnt + 1'b1;
                     end else if (!ovf_flag) begin
                        overflow_nxt = 1'b1;
                        ovf_nxt      = 1'b1;
                     end
                  end else begin
                     bit_nxt   = bit_cnt + 1'b1;
                     shreg_nxt = new_byte[6:0];
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  fsm_nxt  = HIGH;
                  high_nxt = HC_W'(1);
               end else if (low_inc == LOW_END) begin
                  frame_done_nxt  = 1'b1;
                  partial_nxt     = (bit_cnt != 3'd0);
                  frame_bytes_nxt = acc_cnt;
                  low_nxt         = '0;
                  fsm_nxt         = IDLE;
               end else begin
                  low_nxt = low_inc;
               end
            end
            default: fsm_nxt = WAIT_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk6_4mhz or posedge reset) begin
      if (reset) begin
         fsm         <= WAIT_SYNC;
         high_cnt    <= '0;
         low_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         acc_cnt     <= '0;
         ovf_flag    <= 1'b0;
         byteValid   <= 1'b0;
         byteData    <= '0;
         byteIx      <= '0;
         frameDone   <= 1'b0;
         frameBytes  <= '0;
         errGlitch   <= 1'b0;
         errPartial  <= 1'b0;
         errOverflow <= 1'b0;
      end else begin
         fsm         <= fsm_nxt;
         high_cnt    <= high_nxt;
         low_cnt     <= low_nxt;
         bit_cnt     <= bit_nxt;
         shreg       <= shreg_nxt;
         acc_cnt     <= acc_nxt;
         ovf_flag    <= ovf_nxt;
         byteValid   <= byte_valid_nxt;
         byteData    <= byte_data_nxt;
         byteIx      <= byte_ix_nxt;
         frameDone   <= frame_done_nxt;
         frameBytes  <= frame_bytes_nxt;
         errGlitch   <= glitch_nxt;
         errPartial  <= partial_nxt;
         errOverflow <= overflow_nxt;
      end
   end

   assign state = (fsm == HIGH) || (fsm == LOW);

endmodule
